// File: rtl/switch_ingress_buf.sv
// -----------------------------------------------------------------------------
// switch_ingress_buf
//
// Ingress buffer in front of the address-routing switch. The switch cannot
// stall, so this block absorbs source bursts in a DEPTH-entry circular FIFO
// and issues at most one packet per cycle to the switch. It also honours a
// pause input and counts the packets it forwards.
//
// Parameters
//   ADDR_WIDTH  packet address width (matches the switch)
//   DATA_WIDTH  packet data width (matches the switch)
//   DEPTH       FIFO entries, power of two, >= 2
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_vld     source offers a packet
//   in_rdy     buffer can accept a packet this cycle
//   in_addr    source packet address
//   in_data    source packet data
//   hold       pause: no packet is issued while high
//   out_vld    switch vld
//   out_addr   switch addr
//   out_data   switch data
//   level      current FIFO occupancy (0..DEPTH)
//   fwd_cnt    packets issued since reset, wraps at 16 bits
// -----------------------------------------------------------------------------
module switch_ingress_buf #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_vld,
    output logic                     in_rdy,
    input  logic [ADDR_WIDTH-1:0]    in_addr,
    input  logic [DATA_WIDTH-1:0]    in_data,
    input  logic                     hold,
    output logic                     out_vld,
    output logic [ADDR_WIDTH-1:0]    out_addr,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              fwd_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int EW = ADDR_WIDTH + DATA_WIDTH;

    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    // Ready comes only from the registered occupancy: a pop in the same
    // cycle does not open a slot for a simultaneous push when full.
    assign in_rdy = (level != LW'(DEPTH));
    assign push   = in_vld && in_rdy;
    // Pop also uses the registered occupancy, so a packet pushed into an
    // empty FIFO is issued one edge later rather than falling through.
    assign pop    = !hold && (level != '0);

    // Storage has no reset; entries are only read once written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_addr, in_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            out_vld  <= 1'b0;
            out_addr <= '0;
            out_data <= '0;
            fwd_cnt  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end

            if (pop) begin
                rd_ptr   <= rd_ptr + PW'(1);
                out_vld  <= 1'b1;
                out_addr <= mem[rd_ptr][EW-1:DATA_WIDTH];
                out_data <= mem[rd_ptr][DATA_WIDTH-1:0];
                fwd_cnt  <= fwd_cnt + 16'd1;
            end else begin
                out_vld  <= 1'b0;
            end

            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: doc/switch_ingress_buf.md
# switch_ingress_buf

Ingress buffer that sits directly upstream of the address-routing switch and drives its `vld`/`addr`/`data` input. It accepts packets from a source over a valid/ready handshake, stores them in a DEPTH-entry FIFO, and presents them to the switch at one packet per cycle. The switch has no backpressure, so this block provides it: it absorbs bursts and honours a `hold` pause input. It also keeps a free-running count of packets forwarded.

## Interface
- `ADDR_WIDTH`, default 8: packet address width; matches the switch.
- `DATA_WIDTH`, default 16: packet data width; matches the switch.
- `DEPTH`, default 8: FIFO entries; power of two, at least 2.

- `clk`  in  1: clock; all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_vld`  in  1: source offers a packet.
- `in_rdy`  out  1: buffer can accept a packet this cycle.
- `in_addr`  in  ADDR_WIDTH: source packet address.
- `in_data`  in  DATA_WIDTH: source packet data.
- `hold`  in  1: when high, no packet is issued to the switch.
- `out_vld`  out  1: drives switch `vld`.
- `out_addr`  out  ADDR_WIDTH: drives switch `addr`.
- `out_data`  out  DATA_WIDTH: drives switch `data`.
- `level`  out  $clog2(DEPTH)+1: current FIFO occupancy.
- `fwd_cnt`  out  16: packets issued since reset.

## Operation
- Storage is a circular FIFO with write pointer, read pointer and occupancy count. Both pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
- Push occurs when `in_vld && in_rdy` at a rising edge. `{in_addr, in_data}` is written at the write pointer, and the write pointer increments.
- `in_rdy` = (`level` != DEPTH). It is derived only from the registered count. A pop in the same cycle does not make a full FIFO ready (no fall-through).
- Pop occurs when `!hold && level != 0` at a rising edge. The head entry is loaded into the `out_addr`/`out_data` registers, `out_vld` is set to 1, the read pointer increments, and `fwd_cnt` increments.
- When no pop occurs, `out_vld` is set to 0 and `out_addr`/`out_data` keep their last value.
- Simultaneous push and pop: `level` is unchanged and both pointers advance. This is legal at any non-full, non-empty level.
- Push into an empty FIFO and pop in the same cycle cannot happen, because the pop condition uses the registered `level` of 0. The entry is issued on the following edge.
- `fwd_cnt` wraps from 0xFFFF to 0x0000.
- `level` update per edge:
  - +1 on push only.
  - −1 on pop only.
  - unchanged on both or neither.
- `in_vld` while `in_rdy` is 0 is ignored. The source must hold its packet until accepted.
- The block does not inspect `in_addr`; routing belongs to the switch.

## Timing
- Reset (`rst` high at an edge) gives:
  - `out_vld`=0, `out_addr`=0, `out_data`=0;
  - `level`=0, `fwd_cnt`=0, both pointers 0;
  - `in_rdy`=1 from the first cycle after reset.
- Reset mid-operation discards all buffered packets. No `out_vld` pulse occurs in the cycle after reset.
- Latency with empty FIFO and `hold`=0: a packet accepted at edge N appears with `out_vld`=1 in the cycle after edge N+1 (2 cycles).
- Throughput: one push and one pop per cycle sustained. Back-to-back packets produce continuous `out_vld`=1.
- `hold` is sampled at the edge. `hold` high at edge N means `out_vld`=0 after edge N, and the head entry stays in the FIFO.
- Ordering is strict FIFO; no packet is dropped or duplicated.

## Test plan
- Reset, then push a single packet {addr=0x12, data=0xBEEF} with `hold`=0 → `out_vld`=1 exactly one cycle, two cycles after acceptance, with `out_addr`=0x12, `out_data`=0xBEEF, `fwd_cnt`=1, `level` back to 0.
- Hold `hold`=1 and push 8 packets (addr 0..7, data 0x100..0x107) → `level`=8, `in_rdy`=0; a 9th offer is not accepted. Release `hold` → 8 consecutive `out_vld` cycles in order 0..7, and `in_rdy` returns 1 the cycle after the first pop.
- Push and pop continuously for 20 packets with `hold`=0 → `level` stays at most 1 after the first packet, `out_vld` stays high for 20 contiguous cycles, and pointer wrap past 7 preserves data order.
- With FIFO full, hold `in_vld` high and toggle `hold` low for one cycle → exactly one pop, then one push on the next edge, and `level` returns to 8.
- Assert `rst` for one cycle with `level`=5 while `out_vld`=1 → next cycle `out_vld`=0, `level`=0, `fwd_cnt`=0, and none of the 5 buffered packets ever appear.
- Force `fwd_cnt` to 0xFFFE via 0xFFFE forwards, then forward 3 more → `fwd_cnt` reads 0xFFFF, 0x0000, 0x0001.
